// File: rtl/byte_serial_add_sched_pkg.sv
// Purpose : shared types, default sizes and helpers for the byte-serial add scheduler.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: state_t FSM enum, DEF_* default sizes, nslice() slice count, rr_next() round-robin step.
package byte_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;
    localparam int DEF_NREQ  = 2;

    // Number of SLICE-bit steps needed to cover one WIDTH-bit operand.
    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // Pointer to the requester after the one just granted, wrapping at nreq.
    function automatic int rr_next(input int granted, input int nreq);
        return (granted >= nreq - 1) ? 0 : granted + 1;
    endfunction

endpackage

// File: rtl/byte_serial_add_sched_if.sv
// Purpose : request/result bundle between datapath clients and the add scheduler.
// Latency : n/a (wires only).
// Backpressure: req side valid/ready per requester; result side valid/ready.
// Macro BYTE_SERIAL_SUB_EN adds req_sub (per-requester subtract select).
// master = clients/consumer side, slave = scheduler side.
interface byte_serial_add_sched_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    parameter int IDW   = 1
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
`ifdef BYTE_SERIAL_SUB_EN
    logic [NREQ-1:0]       req_sub;
`endif
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;
    logic [IDW-1:0]        res_id;
    logic                  busy;

`ifdef BYTE_SERIAL_SUB_EN
    modport master (
        output req_valid, req_a, req_b, req_sub, res_ready,
        input  req_ready, res_valid, res_sum, res_cout, res_id, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, req_sub, res_ready,
        output req_ready, res_valid, res_sum, res_cout, res_id, busy
    );
`else
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_sum, res_cout, res_id, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_sum, res_cout, res_id, busy
    );
`endif

endinterface

// File: rtl/byte_serial_add_sched_slice_adder.sv
// Purpose : combinational SLICE-bit adder with carry in/out.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_a, i_b operand slices; i_cin carry in; o_sum slice sum; o_cout carry out.
module slice_adder #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};

endmodule

// File: rtl/byte_serial_add_sched.sv
// Purpose : round-robin arbiter + sequencer stepping one SLICE adder LSB-first over WIDTH-bit operands.
// Latency : handshake cycle 0, RUN cycles 1..NSLICE, result valid from cycle NSLICE+1.
// Backpressure: holds result in DONE until res_ready; accepts no request outside IDLE.
// Ports: clk, rst (sync, active-high); bus = slave side of byte_serial_add_sched_if.
// Macro BYTE_SERIAL_SUB_EN: per-request subtract (invert B, carry-in 1); absent = add only.
module byte_serial_add_sched
    import byte_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE,
    parameter int NREQ  = DEF_NREQ
) (
    input logic                   clk,
    input logic                   rst,
    byte_serial_add_sched_if.slave bus
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_sub;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [IDW-1:0]   r_id;
    logic             r_valid;

    logic             w_grant_vld;
    logic [IDW-1:0]   w_grant;
    int               w_idx;
    logic             w_sub_sel;
    logic [SLICE-1:0] w_slice_a;
    logic [SLICE-1:0] w_slice_b;
    logic [SLICE-1:0] w_slice_sum;
    logic             w_slice_cout;

    // First valid requester at or after the round-robin pointer, with wrap.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = 0;
        for (int j = 0; j < NREQ; j++) begin
            w_idx = int'(r_rr_ptr) + j;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_grant_vld && bus.req_valid[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx[IDW-1:0];
            end
        end
    end

`ifdef BYTE_SERIAL_SUB_EN
    assign w_sub_sel = bus.req_sub[w_grant];
`else
    assign w_sub_sel = 1'b0;
`endif

    // Subtraction is A + ~B + 1: B is inverted slice by slice, the +1 enters as the initial carry.
    assign w_slice_a = r_a[r_k*SLICE +: SLICE];
    assign w_slice_b = r_b[r_k*SLICE +: SLICE] ^ {SLICE{r_sub}};

    slice_adder #(.SLICE(SLICE)) u_slice_adder (
        .i_a    (w_slice_a),
        .i_b    (w_slice_b),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_k      <= '0;
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_id     <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_a      <= bus.req_a[w_grant*WIDTH +: WIDTH];
                        r_b      <= bus.req_b[w_grant*WIDTH +: WIDTH];
                        r_sub    <= w_sub_sel;
                        r_carry  <= w_sub_sel;
                        r_id     <= w_grant;
                        r_k      <= '0;
                        r_rr_ptr <= IDW'(rr_next(int'(w_grant), NREQ));
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_k*SLICE +: SLICE] <= w_slice_sum;
                    r_carry                   <= w_slice_cout;
                    if (r_k == KW'(NSLICE - 1)) begin
                        r_cout  <= w_slice_cout;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Ready only in IDLE and only toward the granted requester.
    assign bus.req_ready = (r_state == IDLE && w_grant_vld) ? (NREQ'(1) << w_grant) : '0;
    assign bus.res_valid = r_valid;
    assign bus.res_sum   = r_sum;
    assign bus.res_cout  = r_cout;
    assign bus.res_id    = r_id;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_byte_serial_add_sched.sv
module tb_byte_serial_add_sched;
    import byte_serial_pkg::*;

    localparam int W  = 32;
    localparam int NR = 2;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    byte_serial_add_sched_if #(.NREQ(NR), .WIDTH(W), .IDW(IW)) bus ();

    byte_serial_add_sched #(.WIDTH(W), .SLICE(8), .NREQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int multi_cnt = 0;
    int valid_cnt = 0;

    always @(negedge clk) begin
        if ($countones(bus.req_ready) > 1) multi_cnt++;
        if (bus.res_valid) valid_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] es, input logic ec, input string nm);
        int cnt;
        @(negedge clk);
        bus.req_a[r*W +: W] = a;
        bus.req_b[r*W +: W] = b;
`ifdef BYTE_SERIAL_SUB_EN
        bus.req_sub = '0;
        bus.req_sub[r] = s;
`else
        if (s) $display("note: sub vector %s skipped in add-only build", nm);
`endif
        bus.req_valid[r] = 1'b1;
        #1;
        chk({nm, "_rdy"}, 64'(bus.req_ready), 64'(1 << r));
        @(negedge clk);
        bus.req_valid = '0;
        chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
        cnt = 1;
        while (!bus.res_valid && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        chk({nm, "_lat"}, 64'(cnt), 64'd5);
        chk({nm, "_sum"}, 64'(bus.res_sum), 64'(es));
        chk({nm, "_cout"}, 64'(bus.res_cout), 64'(ec));
        chk({nm, "_id"}, 64'(bus.res_id), 64'(r));
        @(negedge clk);
        chk({nm, "_drop"}, 64'(bus.res_valid), 64'd0);
    endtask

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] es;
        logic        ec;
    } vec_t;

    initial begin
        vec_t tbl[$];
        int   got, cyc, vc0;
        logic [IW-1:0] ids[4];
        logic [31:0]   sums[4];
        logic          stable_ok;

        tbl.push_back('{0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0});
        tbl.push_back('{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1});
        tbl.push_back('{0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0});
        tbl.push_back('{1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1});
        tbl.push_back('{0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0});
        tbl.push_back('{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1});
`ifdef BYTE_SERIAL_SUB_EN
        tbl.push_back('{0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0});
        tbl.push_back('{1, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1});
        tbl.push_back('{0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1});
`endif

        // Reset state
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
`ifdef BYTE_SERIAL_SUB_EN
        bus.req_sub = '0;
`endif
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_sum", 64'(bus.res_sum), 64'd0);
        chk("rst_cout", 64'(bus.res_cout), 64'd0);
        chk("rst_id", 64'(bus.res_id), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rdy", 64'(bus.req_ready), 64'd0);
        rst = 1'b0;

        // Contention: both requesters held valid from reset
        @(negedge clk);
        bus.req_a[0 +: W] = 32'd1;
        bus.req_b[0 +: W] = 32'd1;
        bus.req_a[W +: W] = 32'd10;
        bus.req_b[W +: W] = 32'd20;
        bus.req_valid = 2'b11;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.res_valid) begin
                ids[got]  = bus.res_id;
                sums[got] = bus.res_sum;
                got++;
            end
        end
        bus.req_valid = '0;
        chk("cont_count", 64'(got), 64'd4);
        for (int i = 0; i < got; i++) begin
            chk($sformatf("cont_id%0d", i), 64'(ids[i]), 64'(i % 2));
            chk($sformatf("cont_sum%0d", i), 64'(sums[i]), (i % 2 == 0) ? 64'd2 : 64'd30);
        end
        @(negedge clk);

        // Table-driven single operations
        for (int i = 0; i < tbl.size(); i++) begin
`ifndef BYTE_SERIAL_SUB_EN
            if (tbl[i].s) continue;
`endif
            run_op(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].es, tbl[i].ec, $sformatf("vec%0d", i));
        end

        // Backpressure in DONE
        bus.res_ready = 1'b0;
        @(negedge clk);
        bus.req_a[W +: W] = 32'h11;
        bus.req_b[W +: W] = 32'h22;
        bus.req_valid[1] = 1'b1;
        @(negedge clk);
        bus.req_valid = '0;
        cyc = 0;
        while (!bus.res_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_valid_rise", 64'(bus.res_valid), 64'd1);
        bus.req_a[0 +: W] = 32'h5;
        bus.req_b[0 +: W] = 32'h5;
        bus.req_valid[0] = 1'b1;
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.res_valid !== 1'b1 || bus.res_sum !== 32'h33 || bus.res_id !== 1'b1 ||
                bus.req_ready !== 2'b00 || bus.busy !== 1'b1)
                stable_ok = 1'b0;
            @(negedge clk);
        end
        chk("bp_stable", 64'(stable_ok), 64'd1);
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(bus.res_valid), 64'd0);
        chk("bp_release_busy", 64'(bus.busy), 64'd0);
        chk("bp_hold_sum", 64'(bus.res_sum), 64'h33);
        chk("bp_hold_id", 64'(bus.res_id), 64'd1);

        // Reset after two RUN cycles
        @(negedge clk);
        bus.req_a[0 +: W] = 32'h0909_0909;
        bus.req_b[0 +: W] = 32'h0909_0909;
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        bus.req_valid = '0;
        vc0 = valid_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_valid", 64'(bus.res_valid), 64'd0);
        chk("mid_rst_sum", 64'(bus.res_sum), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_rst_no_result", 64'(valid_cnt), 64'(vc0));
        run_op(0, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, "post_rst");

        chk("one_hot_ready", 64'(multi_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_serial_add_sched.md
Name: byte_serial_add_sched

Overview:
Arbitration and sequencing controller for a shared byte-serial adder. Two or more requesters each offer a WIDTH-bit operand pair. The block grants one requester round-robin, then steps a single SLICE-bit adder across the operand slices LSB-first while carrying between slices. It returns the assembled WIDTH-bit sum with carry-out and requester ID on a valid/ready result port. It sits between multiple datapath clients and one slice adder.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of SLICE
SLICE, 8, adder slice width; NSLICE = WIDTH/SLICE slices per operation
NREQ, 2, number of requesters (>=2); ID width IDW = clog2(NREQ)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  NREQ  per-requester operand valid
req_ready  output  NREQ  per-requester accept; at most one bit high
req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  operand B, same packing
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_sum  output  WIDTH  assembled sum
res_cout  output  1  carry out of top slice
res_id  output  IDW  index of the requester served
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset state: IDLE, rr_ptr=0, slice index k=0, carry=0. Outputs: res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, req_ready=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Combinational grant g = first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[g]=1 and all other bits 0. req_ready is all-zero when no request is valid or the state is not IDLE.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - On handshake: capture A/B of requester g, res_id<=g, carry<=0, k<=0, rr_ptr<=(g+1) mod NREQ, go to RUN.
- RUN:
  - Each cycle, the slice adder computes A[k] + B[k] + carry.
  - The sum is written to res_sum bits [k*SLICE +: SLICE] and carry <= slice cout.
  - If k==NSLICE-1: res_cout <= slice cout, go to DONE. Otherwise k <= k+1.
  - Slices are processed strictly in order 0..NSLICE-1.
- DONE:
  - res_valid=1. res_sum, res_cout, res_id are held stable until res_valid&&res_ready.
  - On that handshake: res_valid <= 0, go to IDLE.
  - res_sum/res_cout/res_id keep their last value after the handshake until the next operation overwrites them.
- Latency: handshake in cycle 0, RUN in cycles 1..NSLICE, res_valid high from cycle NSLICE+1 (cycle 5 with defaults).
- Throughput: minimum NSLICE+2 cycles per operation with res_ready tied high.
- New requests are never accepted outside IDLE, even if res_ready is high in DONE.
- All arithmetic is modulo 2^WIDTH. The carry-out is reported only via res_cout.
- Reset mid-operation (RUN or DONE): operation aborted, no result delivered, all state returns to reset values at the next edge.
- A requester dropping req_valid while not granted has no effect. Operands are sampled only at the handshake edge.

Optional Feature:
Macro BYTE_SERIAL_SUB_EN.
- Defined: adds input req_sub (NREQ bits).
  - The captured sub bit selects subtraction: B is inverted per slice and the initial carry is 1.
  - res_sum = A-B mod 2^WIDTH. res_cout = 1 means no borrow (A>=B unsigned).
- Undefined: port absent, addition only. Logic is identical to sub=0.

Decomposition:
- Package byte_serial_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default SLICE/WIDTH constants
  - NSLICE derivation helper
  - round-robin next-pointer function
- One natural sub-module: slice_adder, a combinational SLICE-bit adder with cin/cout, instantiated once and driven by the controller's slice mux.

Test Plan:
- Requester 0: A=0x0000_00FF, B=0x0000_0001, res_ready=1 -> res_sum=0x0000_0100, res_cout=0, res_id=0, res_valid high exactly 5 cycles after handshake.
- Full carry chain: A=0xFFFF_FFFF, B=0x0000_0001 -> res_sum=0x0000_0000, res_cout=1.
- Contention: both req_valid held high from reset -> served in order 0, 1, 0, 1; req_ready never has two bits set.
- Backpressure: res_ready=0 for 10 cycles in DONE -> res_valid, res_sum, res_id stable and req_ready=0 throughout. Release -> IDLE next cycle.
- Reset asserted after 2 RUN cycles -> res_valid never rises, busy=0 next cycle. A following request A=3, B=4 -> res_sum=7.
- With BYTE_SERIAL_SUB_EN:
  - A=5, B=7, sub=1 -> res_sum=0xFFFF_FFFE, res_cout=0.
  - A=7, B=5, sub=1 -> res_sum=2, res_cout=1.
